// File: rtl/exception_vector_loader.sv
// Exception sequencer: steers the address mux to the vector byte for the highest-priority
// request, waits MEM_LATENCY cycles for the read, then strobes the new PC and EPC for one cycle.
module exception_vector_loader #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  iord_sel,
  output logic        busy,
  output logic        epc_load,
  output logic [31:0] epc_value,
  output logic        pc_load,
  output logic [31:0] pc_value,
  output logic [1:0]  cause
);

  typedef enum logic [1:0] {StIdle, StFetch, StCommit} state_t;

  localparam logic [2:0] LastCount = 3'(MEM_LATENCY - 1);

  state_t     state;
  logic [2:0] wait_cnt;
  logic       req_valid;
  logic [1:0] req_cause;
  logic [2:0] req_sel;

  // Only the vector byte is meaningful on the memory bus.
  logic unused_mem_bits;
  assign unused_mem_bits = ^mem_data_in[31:8];

  always_comb begin
    req_valid = exc_opcode | exc_overflow | exc_divzero;
    req_cause = 2'b00;
    req_sel   = 3'b000;
    if (exc_opcode) begin
      req_cause = 2'b01;
      req_sel   = 3'b010;
    end else if (exc_overflow) begin
      req_cause = 2'b10;
      req_sel   = 3'b011;
    end else if (exc_divzero) begin
      req_cause = 2'b11;
      req_sel   = 3'b100;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      wait_cnt  <= 3'd0;
      iord_sel  <= 3'b000;
      busy      <= 1'b0;
      epc_load  <= 1'b0;
      pc_load   <= 1'b0;
      epc_value <= 32'd0;
      pc_value  <= 32'd0;
      cause     <= 2'b00;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            cause     <= req_cause;
            iord_sel  <= req_sel;
            epc_value <= pc_in - 32'd4;
            wait_cnt  <= 3'd0;
            busy      <= 1'b1;
            state     <= StFetch;
          end
        end
        StFetch: begin
          // Address has been stable for MEM_LATENCY cycles on this edge.
          if (wait_cnt == LastCount) begin
            pc_value <= {24'd0, mem_data_in[7:0]};
            epc_load <= 1'b1;
            pc_load  <= 1'b1;
            iord_sel <= 3'b000;
            state    <= StCommit;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        StCommit: begin
          epc_load <= 1'b0;
          pc_load  <= 1'b0;
          busy     <= 1'b0;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_vector_loader.sv
// Bench for exception_vector_loader: two instances (latency 2 and 1) driven in parallel,
// checked cycle by cycle against expectations computed from the exception rules.
module tb_exception_vector_loader;

  localparam int unsigned LatA = 2;
  localparam int unsigned LatB = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_opcode, exc_overflow, exc_divzero;
  logic [31:0] pc_in;
  logic [31:0] vec_mem [3];  // words at byte addresses 253, 254, 255

  logic [31:0] mem_a, mem_b;
  logic [2:0]  sel_a, sel_b;
  logic        busy_a, busy_b, epl_a, epl_b, pcl_a, pcl_b;
  logic [31:0] epc_a, epc_b, pcv_a, pcv_b;
  logic [1:0]  cause_a, cause_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] prev_pc_a, prev_pc_b;

  always #5 clk = ~clk;

  assign mem_a = (sel_a == 3'b010) ? vec_mem[0] : (sel_a == 3'b011) ? vec_mem[1] :
                 (sel_a == 3'b100) ? vec_mem[2] : 32'h5A5A_5A3C;
  assign mem_b = (sel_b == 3'b010) ? vec_mem[0] : (sel_b == 3'b011) ? vec_mem[1] :
                 (sel_b == 3'b100) ? vec_mem[2] : 32'h5A5A_5A3C;

  exception_vector_loader #(.MEM_LATENCY(LatA)) dut_a (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
    .exc_divzero(exc_divzero), .pc_in(pc_in), .mem_data_in(mem_a), .iord_sel(sel_a),
    .busy(busy_a), .epc_load(epl_a), .epc_value(epc_a), .pc_load(pcl_a), .pc_value(pcv_a),
    .cause(cause_a)
  );

  exception_vector_loader #(.MEM_LATENCY(LatB)) dut_b (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
    .exc_divzero(exc_divzero), .pc_in(pc_in), .mem_data_in(mem_b), .iord_sel(sel_b),
    .busy(busy_b), .epc_load(epl_b), .epc_value(epc_b), .pc_load(pcl_b), .pc_value(pcv_b),
    .cause(cause_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " a outputs"}, {sel_a, busy_a, epl_a, pcl_a, cause_a, 24'd0},
        32'd0);
    chk({tag, " a values"}, epc_a | pcv_a, 32'd0);
    chk({tag, " b outputs"}, {sel_b, busy_b, epl_b, pcl_b, cause_b, 24'd0},
        32'd0);
    chk({tag, " b values"}, epc_b | pcv_b, 32'd0);
  endtask

  // i = cycles since the accepting edge; lat = that instance's memory latency.
  task automatic chk_cycle(input string who, input int lat, input int i,
                           input logic b, input logic [2:0] s, input logic el, input logic pl,
                           input logic [31:0] ev_o, input logic [31:0] pv_o, input logic [1:0] c,
                           input logic [2:0] es, input logic [1:0] ec, input logic [31:0] ep,
                           input logic [31:0] ev, input logic [31:0] prev);
    chk({who, " busy"}, 32'(b), 32'(i <= lat + 1));
    chk({who, " iord_sel"}, 32'(s), (i <= lat) ? 32'(es) : 32'd0);
    chk({who, " epc_load"}, 32'(el), 32'(i == lat + 1));
    chk({who, " pc_load"}, 32'(pl), 32'(i == lat + 1));
    chk({who, " epc_value"}, ev_o, ep);
    chk({who, " pc_value"}, pv_o, (i > lat) ? ev : prev);
    chk({who, " cause"}, 32'(c), 32'(ec));
  endtask

  // Presents a request before edge k, then checks both instances through their return to idle.
  task automatic service(input logic o, input logic v, input logic d, input logic [31:0] pc,
                         input logic [2:0] drop);
    int unsigned addr;
    logic [1:0]  ec;
    logic [2:0]  es;
    logic [31:0] ep, ev;
    ec   = o ? 2'd1 : (v ? 2'd2 : 2'd3);
    addr = 252 + int'(ec);
    es   = (addr == 253) ? 3'b010 : (addr == 254) ? 3'b011 : 3'b100;
    ev   = {24'd0, vec_mem[addr - 253][7:0]};
    ep   = pc - 32'd4;
    {exc_opcode, exc_overflow, exc_divzero} = {o, v, d};
    pc_in = pc;
    @(negedge clk);
    {exc_opcode, exc_overflow, exc_divzero} = 3'b000;
    pc_in = $urandom;
    for (int i = 1; i <= int'(LatA) + 2; i++) begin
      chk_cycle("A", LatA, i, busy_a, sel_a, epl_a, pcl_a, epc_a, pcv_a, cause_a,
                es, ec, ep, ev, prev_pc_a);
      chk_cycle("B", LatB, i, busy_b, sel_b, epl_b, pcl_b, epc_b, pcv_b, cause_b,
                es, ec, ep, ev, prev_pc_b);
      if (i == 1) {exc_opcode, exc_overflow, exc_divzero} = drop;
      if (i == 2) {exc_opcode, exc_overflow, exc_divzero} = 3'b000;
      if (i < int'(LatA) + 2) @(negedge clk);
    end
    prev_pc_a = ev;
    prev_pc_b = ev;
  endtask

  initial begin
    reset = 1'b0;
    {exc_opcode, exc_overflow, exc_divzero} = 3'b000;
    pc_in = 32'd0;
    for (int j = 0; j < 3; j++) vec_mem[j] = $urandom;
    prev_pc_a = 32'd0;
    prev_pc_b = 32'd0;

    #2 reset = 1'b1;
    #1 chk_zero("power-on reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle iord_sel", 32'({sel_a, sel_b}), 32'd0);
    chk("idle busy", 32'({busy_a, busy_b}), 32'd0);

    // Overflow service with the worked example from the block description
    vec_mem[1] = 32'h0000_00A7;
    service(1'b0, 1'b1, 1'b0, 32'h0000_0040, 3'b000);

    // All three requests together: opcode wins
    service(1'b1, 1'b1, 1'b1, $urandom, 3'b000);

    // Divide-by-zero accepted; opcode pulse while busy must be dropped
    vec_mem[2] = $urandom;
    service(1'b0, 1'b0, 1'b1, $urandom, 3'b100);

    // PC wrap and upper-byte masking, both latencies
    vec_mem[0] = 32'hFFFF_FF12;
    service(1'b1, 1'b0, 1'b0, 32'h0000_0000, 3'b000);
    chk("wrap epc", epc_a, 32'hFFFF_FFFC);
    chk("mask pc", pcv_b, 32'h0000_0012);

    // Asynchronous reset mid-cycle clears held results immediately
    #2 reset = 1'b1;
    #1 chk_zero("async reset idle");
    @(negedge clk);
    reset = 1'b0;

    // Reset during FETCH: no strobe may ever appear
    exc_opcode = 1'b1;
    pc_in = $urandom;
    @(negedge clk);
    exc_opcode = 1'b0;
    chk("pre-abort busy", 32'({busy_a, busy_b}), 32'b11);
    #2 reset = 1'b1;
    #1 chk_zero("abort reset");
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("abort strobes", 32'({epl_a, pcl_a, epl_b, pcl_b}), 32'd0);
    end
    reset = 1'b0;
    prev_pc_a = 32'd0;
    prev_pc_b = 32'd0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("post-abort strobes", 32'({epl_a, pcl_a, epl_b, pcl_b, busy_a, busy_b}), 32'd0);
    end
    service(1'b0, 1'b0, 1'b1, $urandom, 3'b000);

    // Randomised back-to-back services
    for (int n = 0; n < 25; n++) begin
      logic [2:0] req, drp;
      for (int j = 0; j < 3; j++) vec_mem[j] = $urandom;
      req = 3'($urandom_range(1, 7));
      drp = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
      service(req[2], req[1], req[0], $urandom, drp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exception_vector_loader.md
# exception_vector_loader

Sequencer that services MIPS-style exceptions in the multicycle datapath by driving the memory-address select toward the fixed exception-vector bytes (253/254/255), waiting for the memory read, and producing the new PC and EPC values. It sits between the control unit, which raises exception flags, and the instruction/data address mux and memory. It owns the address select only while an exception is in service.

## Interface

Parameters:
- MEM_LATENCY, 2, cycles from a stable address on the memory to valid `mem_data_in`; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; one clock domain.
- exc_opcode  input  1  invalid-opcode exception request (level, sampled in IDLE).
- exc_overflow  input  1  arithmetic overflow exception request.
- exc_divzero  input  1  divide-by-zero exception request.
- pc_in  input  32  current PC register value (already PC+4 of the faulting instruction).
- mem_data_in  input  32  memory read data; the vector byte is bits [7:0].
- iord_sel  output  3  address-mux select: 000 = PC source, 010 = 253, 011 = 254, 100 = 255.
- busy  output  1  high in every state except IDLE.
- epc_load  output  1  one-cycle write strobe for EPC.
- epc_value  output  32  pc_in − 4, captured at request acceptance.
- pc_load  output  1  one-cycle write strobe for PC (same cycle as epc_load).
- pc_value  output  32  {24'b0, vector byte}.
- cause  output  2  01 opcode, 10 overflow, 11 divzero, 00 none; held until the next accept.

## Operation

- States: IDLE, FETCH, COMMIT.
- IDLE: iord_sel = 000, busy = 0, strobes = 0. When any request is high at a rising edge, accept it. Priority is exc_opcode > exc_overflow > exc_divzero; lower-priority simultaneous requests are dropped. On accept, register cause, iord_sel (010/011/100), and epc_value = pc_in − 4 (32-bit wrap; pc_in = 0 yields 0xFFFFFFFC). Clear the wait counter and go to FETCH.
- FETCH: iord_sel held constant. The counter increments each cycle. On the edge ending the MEM_LATENCY-th FETCH cycle:
  - capture pc_value = {24'b0, mem_data_in[7:0]};
  - set epc_load = pc_load = 1;
  - set iord_sel = 000;
  - go to COMMIT.
- COMMIT: strobes high for exactly one cycle. On the next edge, clear the strobes and return to IDLE.
- Requests arriving while busy = 1 are ignored, not queued. A request still high when IDLE is re-entered is accepted normally on that edge.
- pc_value, epc_value and cause hold their last values in IDLE; they change only on accept/capture.
- Reset (any time, including mid-FETCH or COMMIT):
  - state forced to IDLE;
  - all outputs forced to 0 (iord_sel = 000, pc_value = epc_value = 0, cause = 00);
  - no strobe is emitted for the aborted exception.
- mem_data_in bits [31:8] are ignored.

## Timing

- All outputs are registered; there is no combinational path from inputs to outputs.
- Request high at edge k:
  - busy and iord_sel are valid from k+1 through k+MEM_LATENCY;
  - epc_value is valid from k+1;
  - pc_value is valid and the strobes are high during cycle k+MEM_LATENCY+1;
  - busy falls at k+MEM_LATENCY+2.
- Service occupancy is MEM_LATENCY+1 cycles; the earliest next accept is at edge k+MEM_LATENCY+2.
- mem_data_in is sampled only at the final FETCH edge. The address has then been stable for MEM_LATENCY cycles.

## Test plan

- Reset behaviour: assert reset asynchronously mid-cycle → all outputs 0 immediately. Deassert, then idle 3 cycles → iord_sel = 000, busy = 0.
- Overflow service: pc_in = 0x00000040, exc_overflow pulse at edge k, memory returns 0x000000A7 while iord_sel = 011 (MEM_LATENCY = 2):
  - iord_sel = 011 during cycles k+1..k+2;
  - cycle k+3: epc_value = 0x3C, pc_value = 0xA7, cause = 10, single-cycle epc_load/pc_load;
  - iord_sel = 000 at k+3.
- Priority: exc_opcode, exc_overflow and exc_divzero all high at the same edge → iord_sel = 010, cause = 01. Only one commit pulse occurs.
- Busy-drop: exc_divzero accepted; exc_opcode pulses at k+1 while busy → ignored. Result: exactly one commit with cause = 11 and pc_value from address 255.
- Reset mid-FETCH: exc_opcode accepted, reset asserted at k+1 → no pc_load/epc_load ever appears. After release, a new exc_divzero is serviced normally.
- Wrap and byte masking: pc_in = 0, exc_opcode, memory word 0xFFFFFF12 → epc_value = 0xFFFFFFFC, pc_value = 0x00000012. Repeat with MEM_LATENCY = 1 → commit at k+2.
